// File: rtl/qspi_resp_pkg.sv
// Shared opcodes, phase lengths and FSM states for the QSPI ROM responder.
package qspi_resp_pkg;

  localparam logic [7:0] OP_QREAD = 8'hEB;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRSR  = 8'h01;
  localparam logic [7:0] OP_RES   = 8'hAB;
  localparam logic [7:0] OP_MRST  = 8'hFF;

  localparam int ADDR_NIB  = 6;
  localparam int MODE_NIB  = 2;
  localparam int DUMMY_CLK = 4;

  typedef enum logic [2:0] {
    IDLE, CMD, WRSR, ADDR, MODE, DUMMY, DATA, IGNORE
  } state_t;

endpackage

// File: rtl/qspi_pin_sync.sv
// SPI pin capture with CS/SCLK edge detection; QSPI_RESP_SYNC_EN adds
// two-flop synchronizers ahead of the capture stage.
module qspi_pin_sync
  import qspi_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       sclk,
  input  logic [3:0] io_raw,
  output logic       sclk_rise,
  output logic       cs_rise,
  output logic       cs_fall,
  output logic [3:0] io
);

  logic [5:0] raw;

`ifdef QSPI_RESP_SYNC_EN
  logic [5:0] meta, sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= {io_raw, sclk, cs_n};
      sync <= meta;
    end
  end

  assign raw = sync;
`else
  assign raw = {io_raw, sclk, cs_n};
`endif

  logic cs_s, cs_p, sclk_s, sclk_p;

  // CS resets to "low" so a reset taken mid-transaction never fakes a CS fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io     <= '0;
      sclk_s <= 1'b0;
      cs_s   <= 1'b0;
      sclk_p <= 1'b0;
      cs_p   <= 1'b0;
    end else begin
      {io, sclk_s, cs_s} <= raw;
      sclk_p             <= sclk_s;
      cs_p               <= cs_s;
    end
  end

  // A CS rise in the same cycle masks the SCLK rise
  assign sclk_rise = sclk_s & ~sclk_p & ~cs_s;
  assign cs_rise   = cs_s & ~cs_p;
  assign cs_fall   = ~cs_s & cs_p;

endmodule

// File: rtl/qspi_rom_responder.sv
// Quad-SPI flash target serving 0xEB quad reads from a synchronous byte memory.
// Optional pin synchronizers are enabled with QSPI_RESP_SYNC_EN.
module qspi_rom_responder
  import qspi_resp_pkg::*;
#(
  parameter int   ADDR_W   = 14,
  parameter logic QE_RESET = 1'b0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic [3:0]        spi_io_in,
  output logic [3:0]        spi_io_out,
  output logic [3:0]        spi_io_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              qe,
  output logic              cont_mode
);

  state_t state, state_n;
  logic sclk_rise, cs_rise, cs_fall;
  logic [3:0] io;
  logic [3:0] cnt, rise_cnt, ones_cnt;
  logic [7:0] shreg, cmd, sr1, sr1_buf, pref;
  logic cmd_valid, wel, qe_buf, nib_lo, rd_d;
  logic [1:0] byte_cnt, mode_hi;
  logic [ADDR_W-1:0] addr_sh;
  logic [7:0] byte_in, next_byte;
  logic unused_sr1;

  qspi_pin_sync u_pin_sync (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .cs_n      (spi_cs_n),
    .sclk      (spi_sclk),
    .io_raw    (spi_io_in),
    .sclk_rise (sclk_rise),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall),
    .io        (io)
  );

  assign byte_in    = {shreg[6:0], io[0]};
  // Fresh read data bypasses the prefetch register when the next rise is back-to-back
  assign next_byte  = rd_d ? mem_rdata : pref;
  assign unused_sr1 = ^sr1;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (cs_rise) begin
      state_n = IDLE;
    end else if (cs_fall) begin
      state_n = cont_mode ? ADDR : CMD;
    end else if (sclk_rise) begin
      case (state)
        CMD: if (cnt == 4'd7) begin
          if (byte_in == OP_QREAD)     state_n = qe ? ADDR : IGNORE;
          else if (byte_in == OP_WRSR) state_n = WRSR;
          else                         state_n = IGNORE;
        end
        ADDR:    if (cnt == 4'(ADDR_NIB - 1))  state_n = MODE;
        MODE:    if (cnt == 4'(MODE_NIB - 1))  state_n = DUMMY;
        DUMMY:   if (cnt == 4'(DUMMY_CLK - 1)) state_n = DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      spi_io_out <= '0;
      spi_io_oe  <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      qe         <= QE_RESET;
      cont_mode  <= 1'b0;
      cnt        <= '0;
      rise_cnt   <= '0;
      ones_cnt   <= '0;
      shreg      <= '0;
      cmd        <= '0;
      sr1        <= '0;
      sr1_buf    <= '0;
      pref       <= '0;
      cmd_valid  <= 1'b0;
      wel        <= 1'b0;
      qe_buf     <= 1'b0;
      nib_lo     <= 1'b0;
      rd_d       <= 1'b0;
      byte_cnt   <= '0;
      mode_hi    <= '0;
      addr_sh    <= '0;
    end else begin
      mem_rd <= 1'b0;
      rd_d   <= mem_rd;
      if (rd_d) pref <= mem_rdata;

      if (cs_rise) begin
        spi_io_oe <= 4'h0;
        nib_lo    <= 1'b0;
        if (state == WRSR) begin
          if (wel && byte_cnt != 2'd0) sr1 <= sr1_buf;
          if (wel && byte_cnt >= 2'd2) qe  <= qe_buf;
          wel <= 1'b0;
        end else if (cmd_valid && rise_cnt == 4'd8 && cmd == OP_WREN) begin
          wel <= 1'b1;
        end
        // Mode reset is recognised whatever state the window started in
        if (rise_cnt == 4'd8 && ones_cnt == 4'd8) cont_mode <= 1'b0;
      end else if (cs_fall) begin
        cnt       <= '0;
        rise_cnt  <= '0;
        ones_cnt  <= '0;
        byte_cnt  <= '0;
        cmd_valid <= 1'b0;
      end else if (sclk_rise && state != IDLE) begin
        if (rise_cnt != 4'hF)          rise_cnt <= rise_cnt + 4'd1;
        if (io[0] && ones_cnt != 4'hF) ones_cnt <= ones_cnt + 4'd1;
        if (state_n != state || (state == WRSR && cnt == 4'd7)) cnt <= '0;
        else                                                      cnt <= cnt + 4'd1;

        case (state)
          CMD: begin
            shreg <= byte_in;
            if (cnt == 4'd7) begin
              cmd       <= byte_in;
              cmd_valid <= 1'b1;
            end
          end
          WRSR: begin
            shreg <= byte_in;
            if (cnt == 4'd7) begin
              if (byte_cnt == 2'd0) sr1_buf <= byte_in;
              if (byte_cnt == 2'd1) qe_buf  <= byte_in[1];
              if (byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
            end
          end
          ADDR: begin
            addr_sh <= {addr_sh[ADDR_W-5:0], io};
            if (cnt == 4'(ADDR_NIB - 1)) begin
              mem_rd   <= 1'b1;
              mem_addr <= {addr_sh[ADDR_W-5:0], io};
            end
          end
          MODE: begin
            if (cnt == 4'(MODE_NIB - 1)) cont_mode <= (mode_hi == 2'b10);
            else                         mode_hi   <= io[1:0];
          end
          DUMMY: begin
            if (state_n == DATA) begin
              spi_io_oe  <= 4'hF;
              spi_io_out <= next_byte[7:4];
              nib_lo     <= 1'b1;
            end
          end
          DATA: begin
            if (nib_lo) begin
              spi_io_out <= next_byte[3:0];
              mem_addr   <= mem_addr + 1'b1;
              mem_rd     <= 1'b1;
              nib_lo     <= 1'b0;
            end else begin
              spi_io_out <= next_byte[7:4];
              nib_lo     <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
